// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer: sequential advance, branch/irq/debug redirects via FLUSH
// Optional debug mode is compiled in when ECAP5_DPROC_DEBUG_EN is defined.
module pc_sequencer #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     INSN_BYTES = 4,
    parameter logic [XLEN-1:0] BOOT_ADDR  = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] IRQ_ADDR   = XLEN'(32'hFF00_000A),
    parameter logic [XLEN-1:0] DBG_ADDR   = XLEN'(32'hFF00_000B)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    input  logic            pc_ready_i,
    output logic            flush_o,
    input  logic            redirect_i,
    input  logic [2:0]      branch_cond_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            irq_i,
    input  logic            irq_en_i,
    output logic [XLEN-1:0] epc_o,
    input  logic            dbg_req_i,
    input  logic            dbg_resume_i,
    output logic [XLEN-1:0] dpc_o,
    output logic            in_debug_o
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_epc;
    logic            r_valid;
    logic            r_flush;
    logic            r_irq_pending;

    logic            w_cond;
    logic            w_taken;
    logic            w_in_debug;
    logic            w_irq_take;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_ret_pc;
    logic            w_unused_tgt0;

    always_comb begin
        w_cond = 1'b0;
        case (branch_cond_i)
            3'd0:    w_cond = 1'b1;
            3'd1:    w_cond = (op_a_i == op_b_i);
            3'd2:    w_cond = (op_a_i != op_b_i);
            3'd3:    w_cond = ($signed(op_a_i) <  $signed(op_b_i));
            3'd4:    w_cond = (op_a_i <  op_b_i);
            3'd5:    w_cond = ($signed(op_a_i) >= $signed(op_b_i));
            3'd6:    w_cond = (op_a_i >= op_b_i);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken       = redirect_i & w_cond;
    assign w_target      = {target_i[XLEN-1:1], 1'b0};
    assign w_unused_tgt0 = target_i[0];
    // A taken branch coinciding with a trap is preserved as the return address.
    assign w_ret_pc      = w_taken ? w_target : r_pc;
    assign w_irq_take    = (r_irq_pending | irq_i) & irq_en_i & ~w_in_debug;

`ifdef ECAP5_DPROC_DEBUG_EN
    logic            r_in_debug;
    logic [XLEN-1:0] r_dpc;
    assign w_in_debug = r_in_debug;
    assign in_debug_o = r_in_debug;
    assign dpc_o      = r_dpc;
`else
    logic w_unused_dbg;
    assign w_in_debug   = 1'b0;
    assign in_debug_o   = 1'b0;
    assign dpc_o        = '0;
    assign w_unused_dbg = dbg_req_i | dbg_resume_i | (|DBG_ADDR);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_BOOT;
            r_pc          <= BOOT_ADDR;
            r_epc         <= '0;
            r_valid       <= 1'b0;
            r_flush       <= 1'b0;
            r_irq_pending <= 1'b0;
`ifdef ECAP5_DPROC_DEBUG_EN
            r_in_debug    <= 1'b0;
            r_dpc         <= '0;
`endif
        end else begin
            r_flush <= 1'b0;
            if (irq_i) begin
                r_irq_pending <= 1'b1;
            end
            case (r_state)
                S_BOOT, S_FLUSH: begin
                    r_state <= S_RUN;
                    r_valid <= 1'b1;
                end
                S_RUN: begin
`ifdef ECAP5_DPROC_DEBUG_EN
                    if (dbg_req_i && !r_in_debug) begin
                        r_dpc      <= w_ret_pc;
                        r_pc       <= DBG_ADDR;
                        r_in_debug <= 1'b1;
                        r_state    <= S_FLUSH;
                        r_valid    <= 1'b0;
                        r_flush    <= 1'b1;
                    end else if (dbg_resume_i && r_in_debug) begin
                        r_pc       <= r_dpc;
                        r_in_debug <= 1'b0;
                        r_state    <= S_FLUSH;
                        r_valid    <= 1'b0;
                        r_flush    <= 1'b1;
                    end else
`endif
                    if (w_irq_take) begin
                        r_epc         <= w_ret_pc;
                        r_pc          <= IRQ_ADDR;
                        r_irq_pending <= 1'b0;
                        r_state       <= S_FLUSH;
                        r_valid       <= 1'b0;
                        r_flush       <= 1'b1;
                    end else if (w_taken) begin
                        r_pc    <= w_target;
                        r_state <= S_FLUSH;
                        r_valid <= 1'b0;
                        r_flush <= 1'b1;
                    end else if (r_valid && pc_ready_i) begin
                        r_pc <= r_pc + XLEN'(INSN_BYTES);
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o       = r_pc;
    assign pc_valid_o = r_valid;
    assign flush_o    = r_flush;
    assign epc_o      = r_epc;

endmodule
